// File: rtl/menu_input_pkg.sv
// Shared definitions for the menu input front end.
//   KEY_NONE/KEY_NEXT/KEY_PREV : 2-bit direction codes read by the menu
//   key_state_t                : direction FSM states
//   max2()                     : elaboration-time helper for counter sizing
package menu_input_pkg;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_NEXT = 2'b01;
  localparam logic [1:0] KEY_PREV = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP,
    S_WAIT_RELEASE
  } key_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   raw_in    : asynchronous raw button level
//   level_out : debounced level; flips only after DEBOUNCE_CYCLES consecutive
//               cycles in which the synchronised level differs from it
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out
);

  localparam int              CW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   LIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: the reset is sampled on the clock edge only; every state element,
  // including the synchroniser flops, is cleared so the button is re-debounced.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      level_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync1->sync2 a true two-stage
      // pipeline; blocking ones would collapse it into a single flop.
      sync1 <= raw_in;
      sync2 <= sync1;
      if (sync2 == level_out) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        level_out <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/menu_input_encoder.sv
// Menu input front end: debounces next/prev/decide buttons and encodes them
// into a direction code with hold-to-auto-repeat, plus an armed decide level.
//   clk            : system clock
//   rst            : synchronous active-high reset
//   btn_next_in    : raw next button, 1 = pressed
//   btn_prev_in    : raw prev button, 1 = pressed
//   btn_decide_in  : raw decide button, 1 = pressed
//   enable_in      : consumer ready; both outputs forced to 0 while low
//   key_input_out  : 00 none, 01 next, 10 prev (11 never driven)
//   decide_out     : high while an armed decide press is held
// Every new direction code is preceded by at least one 00 cycle, since the
// menu only acts on a 00->code edge.
module menu_input_encoder
  import menu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 13000000,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next_in,
  input  logic       btn_prev_in,
  input  logic       btn_decide_in,
  input  logic       enable_in,
  output logic [1:0] key_input_out,
  output logic       decide_out
);

  localparam int CW = $clog2(max2(max2(REPEAT_DELAY, REPEAT_PERIOD),
                                  max2(GAP_CYCLES, DEBOUNCE_CYCLES))) + 1;
  localparam logic [CW-1:0] DELAY_LIM  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LIM = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LIM    = CW'(GAP_CYCLES - 1);

  logic db_next;
  logic db_prev;
  logic db_decide;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .raw_in(btn_next_in), .level_out(db_next)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst(rst), .raw_in(btn_prev_in), .level_out(db_prev)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_decide (
    .clk(clk), .rst(rst), .raw_in(btn_decide_in), .level_out(db_decide)
  );

  key_state_t    state;
  logic [1:0]    code;       // direction being held or repeated
  logic [1:0]    key_q;
  logic [CW-1:0] rpt_cnt;    // repeat timer in S_HOLD, gap timer in S_GAP
  logic          first;      // next repeat uses the long initial delay
  logic          armed;
  logic          db_decide_q;

  // The held button and the opposing one, relative to the current code.
  logic own;
  logic other;

  // NOTE: both outputs are given a value before the conditional so this block
  // never infers a latch.
  always_comb begin
    own   = db_prev;
    other = db_next;
    if (code == KEY_NEXT) begin
      own   = db_next;
      other = db_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      code        <= KEY_NONE;
      key_q       <= KEY_NONE;
      rpt_cnt     <= '0;
      first       <= 1'b0;
      armed       <= 1'b0;
      db_decide_q <= 1'b0;
    end else begin
      // Arm only on a debounced rising edge seen while enabled; a press that
      // was already down when enable rose can never arm.
      db_decide_q <= db_decide;
      armed       <= enable_in && db_decide && (armed || !db_decide_q);

      case (state)
        S_IDLE: begin
          if (db_next && db_prev) begin
            state <= S_WAIT_RELEASE;
          end else if (enable_in && (db_next ^ db_prev)) begin
            state   <= S_HOLD;
            code    <= db_next ? KEY_NEXT : KEY_PREV;
            key_q   <= db_next ? KEY_NEXT : KEY_PREV;
            rpt_cnt <= '0;
            first   <= 1'b1;
          end
        end

        S_HOLD: begin
          if (!own && !other) begin
            state <= S_IDLE;
            key_q <= KEY_NONE;
          end else if (other || !enable_in) begin
            state <= S_WAIT_RELEASE;
            key_q <= KEY_NONE;
          end else if (rpt_cnt == (first ? DELAY_LIM : PERIOD_LIM)) begin
            state   <= S_GAP;
            key_q   <= KEY_NONE;
            rpt_cnt <= '0;
            first   <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (rpt_cnt == GAP_LIM) begin
            rpt_cnt <= '0;
            if (own && !other && enable_in) begin
              state <= S_HOLD;
              key_q <= code;
            end else if ((db_next && db_prev) || !enable_in) begin
              state <= S_WAIT_RELEASE;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end

        S_WAIT_RELEASE: begin
          if (!db_next && !db_prev) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          key_q <= KEY_NONE;
        end
      endcase
    end
  end

  // Busy consumer sees silence immediately, not one cycle later.
  assign key_input_out = enable_in ? key_q : KEY_NONE;
  assign decide_out    = enable_in & armed;

endmodule

// File: tb/tb_menu_input_encoder.sv
// Self-checking bench for menu_input_encoder with short timing parameters.
// A behavioural model, driven at every clock edge with the same inputs the
// DUT samples, pushes the expected outputs into a queue; an independent
// monitor pops and compares them on the falling edge.
module tb_menu_input_encoder;
  import menu_input_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int GAP = 2;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_decide = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] key;
  logic       decide;

  menu_input_encoder #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_next_in(btn_next), .btn_prev_in(btn_prev), .btn_decide_in(btn_decide),
    .enable_in(enable),
    .key_input_out(key), .decide_out(decide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] key;
    logic       dec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, actual, required);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit         s1_m[3];
  bit         s2_m[3];
  bit         db_m[3];
  bit [DEB-1:0] hist[3];      // last DEB synchronised samples per button
  int         mode = M_IDLE;
  int         age  = 0;       // cycles since the direction was first emitted
  logic [1:0] code_m = KEY_NONE;
  bit         armed_m = 0;
  bit         prev_dec_m = 0;

  // Repeat schedule as a timeline: RD code cycles, then repeating
  // GAP silent cycles followed by RP code cycles.
  function automatic int sched_pos(input int a);
    return (a - RD) % (RP + GAP);
  endfunction

  function automatic bit in_gap(input int a);
    if (a < RD) return 1'b0;
    return sched_pos(a) < GAP;
  endfunction

  task automatic model_step();
    bit   r[3];
    bit   n, p, own, other;
    exp_t e;
    r[0] = btn_next;
    r[1] = btn_prev;
    r[2] = btn_decide;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        s1_m[i] = 0; s2_m[i] = 0; db_m[i] = 0; hist[i] = '0;
      end
      mode = M_IDLE; age = 0; code_m = KEY_NONE; armed_m = 0; prev_dec_m = 0;
      e.key = KEY_NONE;
      e.dec = 1'b0;
      exp_q.push_back(e);
      return;
    end

    n = db_m[0];
    p = db_m[1];
    case (mode)
      M_IDLE: begin
        if (n && p) mode = M_LOCK;
        else if (enable && (n != p)) begin
          mode = M_HOLD; age = 0; code_m = n ? KEY_NEXT : KEY_PREV;
        end
      end
      M_HOLD: begin
        own   = (code_m == KEY_NEXT) ? n : p;
        other = (code_m == KEY_NEXT) ? p : n;
        if (!in_gap(age)) begin
          if (!own && !other)       mode = M_IDLE;
          else if (other || !enable) mode = M_LOCK;
          else                       age++;
        end else if (sched_pos(age) == GAP - 1) begin
          if (own && !other && enable)   age++;
          else if ((n && p) || !enable)  mode = M_LOCK;
          else                           mode = M_IDLE;
        end else begin
          age++;
        end
      end
      default: begin
        if (!n && !p) mode = M_IDLE;
      end
    endcase
    e.key = (mode == M_HOLD && !in_gap(age)) ? code_m : KEY_NONE;

    armed_m    = enable && db_m[2] && (armed_m || !prev_dec_m);
    prev_dec_m = db_m[2];
    e.dec      = armed_m;

    // A level changes once the last DEB synchronised samples all disagree.
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][DEB-2:0], s2_m[i]};
      if (hist[i] == {DEB{~db_m[i]}}) db_m[i] = ~db_m[i];
      s2_m[i] = s1_m[i];
      s1_m[i] = r[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t       e;
    logic [1:0] prev_key = KEY_NONE;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("key_input", {30'd0, key}, {30'd0, enable ? e.key : KEY_NONE});
        check("decide", {31'd0, decide}, {31'd0, enable ? e.dec : 1'b0});
        check("code_11_driven", {31'd0, key == 2'b11}, 32'd0);
        check("direct_code_swap",
              {31'd0, (prev_key != KEY_NONE) && (key != KEY_NONE) && (key != prev_key)}, 32'd0);
        prev_key = key;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    run(3);
    rst = 1'b0;

    // Clean next press held 12 cycles.
    run(10);
    btn_next = 1'b1; run(12);
    btn_next = 1'b0; run(15);

    // Bouncing next never settles.
    for (int i = 0; i < 15; i++) begin
      btn_next = ~btn_next; run(2);
    end
    btn_next = 1'b0; run(15);

    // Long hold: auto-repeat schedule.
    btn_next = 1'b1; run(60);
    btn_next = 1'b0; run(15);

    // Lockout with both buttons, then a fresh prev press.
    btn_next = 1'b1; run(15);
    btn_prev = 1'b1; run(10);
    btn_prev = 1'b0; run(10);
    btn_next = 1'b0; run(10);
    btn_prev = 1'b1; run(12);
    btn_prev = 1'b0; run(10);

    // Decide held across enable rising must not fire; a new press does.
    enable = 1'b0; btn_decide = 1'b1; run(10);
    enable = 1'b1; run(10);
    btn_decide = 1'b0; run(10);
    btn_decide = 1'b1; run(12);
    btn_decide = 1'b0; run(10);

    // Reset pulse in the middle of a hold.
    btn_next = 1'b1; run(12);
    rst = 1'b1; run(1);
    rst = 1'b0; run(12);
    btn_next = 1'b0; run(10);

    // Randomised segments: short ones act as bounce, long ones as holds.
    for (int s = 0; s < 300; s++) begin
      btn_next   = ($urandom_range(0, 99) < 40);
      btn_prev   = ($urandom_range(0, 99) < 25);
      btn_decide = ($urandom_range(0, 99) < 35);
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1; run(1); rst = 1'b0;
      end
      run($urandom_range(1, 40));
    end
    btn_next = 1'b0; btn_prev = 1'b0; btn_decide = 1'b0; enable = 1'b1;
    run(20);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
